// File: rtl/hw_status_led.sv
// Multi-channel status-LED driver (OFF/ON/BLINK/STRETCH/CODE) with shared tick prescaler and heartbeat.
// Optional brightness PWM on lit channels is enabled by defining HW_STATUS_LED_PWM_EN.
module hw_status_led #(
  parameter int unsigned FREQ       = 120000000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned NCH        = 4,
  parameter int unsigned STRETCH_MS = 50,
  parameter bit          LED_ACTIVE = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic [3*NCH-1:0] iMODE,
  input  logic [4*NCH-1:0] iARG,
  input  logic [NCH-1:0]   iEVENT,
`ifdef HW_STATUS_LED_PWM_EN
  input  logic [3:0]       iBRIGHT,
`endif
  output logic [NCH-1:0]   oLED,
  output logic             oHEART,
  output logic             oTICK
);

  localparam int unsigned TICK_DIV     = FREQ / TICK_HZ;
  localparam int unsigned PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [31:0] HB_LAST      = 32'(FREQ / 2 - 1);
  localparam logic [10:0] STRETCH_LOAD = 11'(STRETCH_MS);
  localparam logic [10:0] CODE_ON      = 11'd200;
  localparam logic [10:0] CODE_GAP     = 11'd1000;

  typedef enum logic [2:0] {
    M_OFF, M_ON, M_BLINK, M_STRETCH, M_CODE, M_RSV5, M_RSV6, M_RSV7
  } mode_t;

  typedef enum logic [1:0] {C_IDLE, C_ON, C_OFF, C_GAP} code_t;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   hb_cnt;
  logic          heart;
  logic          pwm_on;

  // Prescaler: tick is high for the one cycle following the wrap of presc.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + PW'(1);
      tick  <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hb_cnt <= '0;
      heart  <= 1'b1;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      heart  <= ~heart;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end

  assign oTICK  = tick;
  assign oHEART = heart;

`ifdef HW_STATUS_LED_PWM_EN
  localparam int unsigned PWM_STEP = (TICK_DIV / 16 > 0) ? TICK_DIV / 16 : 1;
  localparam int unsigned SW       = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;

  logic [SW-1:0] pwm_div;
  logic [3:0]    pwm_cnt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pwm_div <= '0;
      pwm_cnt <= '0;
    end else if (pwm_div == SW'(PWM_STEP - 1)) begin
      pwm_div <= '0;
      pwm_cnt <= pwm_cnt + 4'd1;
    end else begin
      pwm_div <= pwm_div + SW'(1);
    end
  end

  assign pwm_on = (pwm_cnt <= iBRIGHT);
`else
  assign pwm_on = 1'b1;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    mode_t       mode_in, mode_q;
    code_t       cst, cst_n;
    logic [10:0] timer, timer_n, half;
    logic [3:0]  arg_q, arg_n, cnt, cnt_n, arg_in;
    logic        phase, phase_n, lit_n, led;

    assign mode_in = mode_t'(iMODE[3*k +: 3]);
    assign arg_in  = iARG[4*k +: 4];
    assign half    = ({7'd0, arg_q} + 11'd1) * 11'd50;

    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        mode_q <= M_OFF;
        cst    <= C_IDLE;
        timer  <= '0;
        arg_q  <= '0;
        cnt    <= '0;
        phase  <= 1'b1;
        led    <= ~LED_ACTIVE;
      end else begin
        mode_q <= mode_in;
        cst    <= cst_n;
        timer  <= timer_n;
        arg_q  <= arg_n;
        cnt    <= cnt_n;
        phase  <= phase_n;
        led    <= (lit_n && pwm_on) ? LED_ACTIVE : ~LED_ACTIVE;
      end
    end

    // Output is decoded from the live iMODE so OFF/ON show up one edge after the input.
    always_comb begin
      timer_n = timer;
      arg_n   = arg_q;
      cnt_n   = cnt;
      phase_n = phase;
      cst_n   = cst;
      lit_n   = 1'b0;
      if (mode_in != mode_q) begin
        timer_n = '0;
        phase_n = 1'b1;
        cnt_n   = '0;
        cst_n   = C_IDLE;
        arg_n   = arg_in;
        if (mode_in == M_STRETCH && iEVENT[k]) timer_n = STRETCH_LOAD;
      end else begin
        case (mode_in)
          M_BLINK: begin
            if (tick) begin
              if (timer + 11'd1 >= half) begin
                timer_n = '0;
                phase_n = ~phase;
                arg_n   = arg_in;
              end else begin
                timer_n = timer + 11'd1;
              end
            end
          end
          M_STRETCH: begin
            if (iEVENT[k]) timer_n = STRETCH_LOAD;
            else if (tick && timer != '0) timer_n = timer - 11'd1;
          end
          M_CODE: begin
            case (cst)
              C_IDLE: begin
                arg_n   = arg_in;
                cnt_n   = '0;
                timer_n = '0;
                cst_n   = C_ON;
              end
              C_ON: begin
                if (tick) begin
                  if (timer + 11'd1 >= CODE_ON) begin
                    timer_n = '0;
                    cst_n   = C_OFF;
                  end else begin
                    timer_n = timer + 11'd1;
                  end
                end
              end
              C_OFF: begin
                if (tick) begin
                  if (timer + 11'd1 >= CODE_ON) begin
                    timer_n = '0;
                    if (cnt == arg_q) begin
                      cnt_n = '0;
                      cst_n = C_GAP;
                    end else begin
                      cnt_n = cnt + 4'd1;
                      cst_n = C_ON;
                    end
                  end else begin
                    timer_n = timer + 11'd1;
                  end
                end
              end
              C_GAP: begin
                if (tick) begin
                  if (timer + 11'd1 >= CODE_GAP) begin
                    timer_n = '0;
                    arg_n   = arg_in;
                    cst_n   = C_ON;
                  end else begin
                    timer_n = timer + 11'd1;
                  end
                end
              end
              default: cst_n = C_IDLE;
            endcase
          end
          default: ;
        endcase
      end
      case (mode_in)
        M_ON:      lit_n = 1'b1;
        M_BLINK:   lit_n = phase_n;
        M_STRETCH: lit_n = (timer_n != '0);
        M_CODE:    lit_n = (cst_n == C_IDLE) || (cst_n == C_ON);
        default:   lit_n = 1'b0;
      endcase
    end

    assign oLED[k] = led;
  end

endmodule

// File: tb/tb_hw_status_led.sv
// Directed bench for hw_status_led at FREQ=20000, TICK_DIV=20, STRETCH_MS=5, NCH=4.
module tb_hw_status_led;
  localparam int unsigned NCH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3*NCH-1:0] mode;
  logic [4*NCH-1:0] arg;
  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   led;
  logic             heart, tick;
`ifdef HW_STATUS_LED_PWM_EN
  logic [3:0]       bright;
`endif

  int unsigned cyc;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;

  hw_status_led #(
    .FREQ(20000), .TICK_HZ(1000), .NCH(4), .STRETCH_MS(5), .LED_ACTIVE(1'b1)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iMODE(mode), .iARG(arg), .iEVENT(ev),
`ifdef HW_STATUS_LED_PWM_EN
    .iBRIGHT(bright),
`endif
    .oLED(led), .oHEART(heart), .oTICK(tick)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; edge N is the Nth posedge after release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int unsigned e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First edge after e at which the channels see a tick (oTICK high after edges 20, 40, ...).
  function automatic int unsigned next_tick(input int unsigned e);
    if (e < 21) return 21;
    return ((e - 1) / 20 + 1) * 20 + 1;
  endfunction

  task automatic set_mode(input int unsigned ch, input logic [2:0] m);
    mode[3*ch +: 3] = m;
  endtask

  task automatic set_arg(input int unsigned ch, input logic [3:0] a);
    arg[4*ch +: 4] = a;
  endtask

  int unsigned t1, u1, cnt;

  initial begin
    rst_n = 1'b0;
    mode  = '0;
    arg   = '0;
    ev    = '0;
`ifdef HW_STATUS_LED_PWM_EN
    bright = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_heart", 32'(heart), 32'h1);
    chk("rst_tick", 32'(tick), 32'h0);
    #2 rst_n = 1'b1;

    wait_until(19); chk("tick_19", 32'(tick), 0);
    wait_until(20); chk("tick_20", 32'(tick), 1);
    wait_until(21); chk("tick_21", 32'(tick), 0);
    wait_until(40); chk("tick_40", 32'(tick), 1);
    chk("led_idle", 32'(led), 0);

    // BLINK on ch0, arg 0 -> 50-tick half periods, then arg 1 -> 100 ticks
    wait_until(45); set_mode(0, 3'd2); set_arg(0, 4'd0);
    wait_until(46); chk("blink_start", 32'(led[0]), 1);
    t1 = next_tick(46);
    wait_until(t1 + 49*20 - 1); chk("blink_t50m1", 32'(led[0]), 1);
    wait_until(t1 + 49*20);     chk("blink_t50", 32'(led[0]), 0);
    wait_until(1500); set_arg(0, 4'd1);
    wait_until(t1 + 99*20 - 1); chk("blink_t100m1", 32'(led[0]), 0);
    wait_until(t1 + 99*20);     chk("blink_t100", 32'(led[0]), 1);
    wait_until(t1 + 199*20 - 1); chk("blink_t200m1", 32'(led[0]), 1);
    wait_until(t1 + 199*20);     chk("blink_t200", 32'(led[0]), 0);

    wait_until(4050); set_mode(0, 3'd1); chk("on_before", 32'(led[0]), 0);
    wait_until(4051); chk("blink_to_on", 32'(led[0]), 1);
    wait_until(4060); set_mode(0, 3'd6); ev[0] = 1'b1;
    wait_until(4061); chk("mode6_dark", 32'(led[0]), 0);
    wait_until(4062); chk("mode6_ev_ignored", 32'(led[0]), 0);
    ev[0] = 1'b0;

    // STRETCH on ch1: single event, then retriggered event
    wait_until(4100); set_mode(1, 3'd3);
    wait_until(4101); chk("stretch_idle", 32'(led[1]), 0);
    wait_until(4110); ev[1] = 1'b1;
    wait_until(4111); ev[1] = 1'b0; chk("stretch_lit", 32'(led[1]), 1);
    t1 = next_tick(4111);
    wait_until(t1 + 4*20 - 1); chk("stretch_t5m1", 32'(led[1]), 1);
    wait_until(t1 + 4*20);     chk("stretch_t5", 32'(led[1]), 0);
    wait_until(4300); ev[1] = 1'b1;
    wait_until(4301); ev[1] = 1'b0;
    t1 = next_tick(4301);
    wait_until(t1 + 2*20); ev[1] = 1'b1;
    wait_until(t1 + 2*20 + 1); ev[1] = 1'b0;
    wait_until(t1 + 4*20);     chk("retrig_old_t5", 32'(led[1]), 1);
    wait_until(t1 + 7*20 - 1); chk("retrig_t8m1", 32'(led[1]), 1);
    wait_until(t1 + 7*20);     chk("retrig_t8", 32'(led[1]), 0);

    wait_until(4500); set_mode(3, 3'd3); ev[3] = 1'b1;
    wait_until(4501); ev[3] = 1'b0; chk("stretch_same_cycle", 32'(led[3]), 1);
    wait_until(4510); set_mode(3, 3'd0);
    wait_until(4511); chk("ch3_off", 32'(led[3]), 0);

    wait_until(9999);  chk("heart_9999", 32'(heart), 1);
    wait_until(10000); chk("heart_10000", 32'(heart), 0);

    // CODE on ch2, arg 2; arg changed to 1 mid-sequence takes effect only after the gap
    wait_until(10010); set_mode(2, 3'd4); set_arg(2, 4'd2);
    wait_until(10011); chk("code_start", 32'(led[2]), 1);
    u1 = next_tick(10012);
    wait_until(u1 + 199*20 - 1); chk("code_on_end_m1", 32'(led[2]), 1);
    wait_until(u1 + 199*20);     chk("code_off1", 32'(led[2]), 0);
    wait_until(u1 + 399*20 - 1); chk("code_off1_end_m1", 32'(led[2]), 0);
    wait_until(u1 + 399*20);     chk("code_on2", 32'(led[2]), 1);
    wait_until(u1 + 450*20);     set_arg(2, 4'd1);
    wait_until(u1 + 799*20);     chk("code_on3", 32'(led[2]), 1);
    wait_until(u1 + 999*20);     chk("code_off3", 32'(led[2]), 0);
    wait_until(u1 + 1299*20);    chk("code_gap", 32'(led[2]), 0);
    wait_until(u1 + 2199*20 - 1); chk("code_gap_end_m1", 32'(led[2]), 0);
    wait_until(u1 + 2199*20);    chk("code_repeat", 32'(led[2]), 1);
    wait_until(u1 + 2599*20);    chk("code_r2_on2", 32'(led[2]), 1);
    wait_until(u1 + 2999*20);    chk("code_r2_gap", 32'(led[2]), 0);

    // Async reset while ch3 is mid-CODE: no clock edge between assertion and check
    set_mode(3, 3'd4);
    wait_until(cyc + 1);
    chk("code3_lit", 32'(led[3]), 1);
    chk("heart_pre_rst", 32'(heart), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_heart", 32'(heart), 1);
    chk("async_rst_tick", 32'(tick), 0);
    mode = '0;
    arg  = '0;
    #3 rst_n = 1'b1;
    wait_until(19); chk("rst2_tick_19", 32'(tick), 0);
    wait_until(20); chk("rst2_tick_20", 32'(tick), 1);
    chk("rst2_led", 32'(led), 0);

`ifdef HW_STATUS_LED_PWM_EN
    wait_until(30); set_mode(3, 3'd1); bright = 4'd3;
    wait_until(40);
    cnt = 0;
    repeat (16) begin
      @(posedge clk); #1;
      cnt += 32'(led[3]);
    end
    chk("pwm_b3", cnt, 4);
    bright = 4'd15;
    wait_until(cyc + 2);
    cnt = 0;
    repeat (16) begin
      @(posedge clk); #1;
      cnt += 32'(led[3]);
    end
    chk("pwm_b15", cnt, 16);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
